mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle RV32I control/datapath memory interface.
- Accepts a held mem_read/mem_write request and returns a one-cycle mem_resp after a configurable latency.
- Provides word storage with byte-enable writes.
- Sits opposite the control FSM. Used as instruction/data memory in simulation and as the backing store for the later cache work.

Parameters:
- ADDR_W, 10, word-address bits; storage holds 2**ADDR_W 32-bit words.
- LATENCY, 2, cycles from request acceptance to mem_resp; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_address  input  32  byte address; bits [ADDR_W+1:2] index the array; bits [1:0] and bits above ADDR_W+1 are ignored (address wraps).
- mem_read  input  1  read request; held high until mem_resp.
- mem_write  input  1  write request; held high until mem_resp.
- mem_byte_enable  input  4  write lane enables; bit i covers wdata[8i+7:8i].
- mem_wdata  input  32  write data; stable while mem_write is high.
- mem_rdata  output  32  read data; valid in the mem_resp cycle of a read, held until the next read response.
- mem_resp  output  1  one-cycle completion pulse.
- mem_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert): state=IDLE, mem_resp=0, mem_rdata=0, mem_err=0, latency counter=0.
  - Any in-flight write is discarded.
  - Array contents are not reset.
- States and transitions:
  - IDLE: if mem_read or mem_write is high at the edge, latch address, wdata, byte_enable and op type; load the counter with LATENCY-1; go to WAIT (or RESP if LATENCY=1).
  - WAIT: decrement the counter each cycle; at 0, go to RESP.
    - If the latched request drops while in WAIT: set mem_err, discard the request, go to IDLE.
  - RESP: mem_resp=1 for exactly this cycle.
    - Read: mem_rdata = array[latched index], registered on entry to RESP.
    - Write: at the edge ending RESP, array[idx] byte lanes with enable=1 take the latched wdata; lanes with enable=0 are unchanged.
    - Next state is RECOVER.
  - RECOVER: one cycle with requests ignored, giving the initiator time to drop its request; then IDLE.
- Latency: a request sampled at edge k sees mem_resp high in cycle k+LATENCY; minimum spacing between responses is LATENCY+2 cycles.
- Simultaneous mem_read and mem_write in IDLE: set mem_err and service the request as a write.
- Write with mem_byte_enable=0000: completes normally with mem_resp and modifies no bytes.
- mem_rdata is not updated by writes, and not updated for reads that are aborted.
- A read of an address in the same cycle that an earlier write commits is impossible, because RECOVER separates them; a read after a write returns the new data.
- mem_err clears only on rst_n.

Optional Feature:
- MEM_RESP_STALL_EN
  - Defined:
    - A 7-bit maximal-length LFSR (x^7+x^6+1, seed 7'h5A on reset) advances every cycle.
    - On request acceptance, its two LSBs are added to the counter load, giving 0..3 extra WAIT cycles.
    - This exercises the initiator's mem_resp wait loops.
  - Undefined: latency is fixed at LATENCY and no LFSR is instantiated.

Test Plan:
- Write then read: write addr 0x0000_0010, data 0xDEADBEEF, be=1111 → mem_resp in cycle k+2; a later read of 0x10 returns 0xDEADBEEF with mem_resp one cycle wide.
- Byte-enable write: preload 0x11223344 at 0x20, write 0xAABBCCDD with be=0001, then be=1100 → read returns 0xAABB33DD.
- Address wrap and alignment: with ADDR_W=10, write 0xCAFEF00D to 0x0000_1004, then read 0x0000_0006 → 0xCAFEF00D.
- Protocol errors:
  - Drop mem_read in the first WAIT cycle → no mem_resp, mem_err=1, and the next read still completes.
  - Assert read and write together → treated as a write, mem_err=1.
- Reset mid-write: assert rst_n=0 during WAIT of a write to 0x40 (old 0x0) → mem_resp=0 immediately, and a post-reset read of 0x40 returns 0x0.
- With MEM_RESP_STALL_EN: 64 back-to-back reads → every response latency falls in LATENCY..LATENCY+3, at least two distinct latencies occur, and all data is correct.

Source files
------------

// File: rtl/mem_if.sv
// Memory request/response bus between the control FSM (master) and a memory responder (slave).
// valid/ready: mem_read or mem_write is held high with address/data stable until the one-cycle mem_resp pulse; the initiator then drops it.
interface mem_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp, mem_err
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp, mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word memory that answers held mem_read/mem_write requests with a one-cycle mem_resp after LATENCY cycles.
// Optional MEM_RESP_STALL_EN adds 0..3 pseudo-random extra wait cycles from a 7-bit LFSR.
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_if.slave       bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_RECOVER} state_t;

  state_t              state;
  logic [31:0]         mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic                op_write_q;
  logic [4:0]          cnt;
  logic [31:0]         rdata_q;
  logic                resp_q;
  logic                err_q;
  logic [4:0]          extra;
  logic [4:0]          load_val;
  logic [ADDR_W-1:0]   idx_in;
  logic                req_in;
  logic                req_held;
  logic                unused_addr;

  assign idx_in      = bus.mem_address[ADDR_W+1:2];
  assign unused_addr = ^{bus.mem_address[31:ADDR_W+2], bus.mem_address[1:0]};
  assign req_in      = bus.mem_read | bus.mem_write;
  // A read+write request is serviced as a write, so the write line is the one that must stay held.
  assign req_held    = op_write_q ? bus.mem_write : bus.mem_read;

`ifdef MEM_RESP_STALL_EN
  logic [6:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 7'h5A;
    else        lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
  end

  assign extra = {3'b000, lfsr[1:0]};
`else
  assign extra = 5'd0;
`endif

  assign load_val = 5'(LATENCY - 1) + extra;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      op_write_q <= 1'b0;
      cnt        <= '0;
      rdata_q    <= '0;
      resp_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_in) begin
            idx_q      <= idx_in;
            wdata_q    <= bus.mem_wdata;
            be_q       <= bus.mem_byte_enable;
            op_write_q <= bus.mem_write;
            if (bus.mem_read && bus.mem_write) err_q <= 1'b1;
            if (load_val == 5'd0) begin
              state  <= S_RESP;
              resp_q <= 1'b1;
              cnt    <= '0;
              if (!bus.mem_write) rdata_q <= mem[idx_in];
            end else begin
              state <= S_WAIT;
              cnt   <= load_val;
            end
          end
        end
        S_WAIT: begin
          if (!req_held) begin
            err_q <= 1'b1;
            cnt   <= '0;
            state <= S_IDLE;
          end else if (cnt == 5'd1) begin
            cnt    <= '0;
            state  <= S_RESP;
            resp_q <= 1'b1;
            if (!op_write_q) rdata_q <= mem[idx_q];
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_RESP:    state <= S_RECOVER;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Storage is not reset; writes land at the edge that ends the response cycle.
  always_ff @(posedge clk) begin
    if (state == S_RESP && op_write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_resp  = resp_q;
  assign bus.mem_err   = err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder, checked against a word-level memory model.
module tb_mem_responder;

  localparam int LAT = 2;
`ifdef MEM_RESP_STALL_EN
  localparam int LAT_MAX = LAT + 3;
`else
  localparam int LAT_MAX = LAT;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  mem_if      bus ();

  mem_responder #(.ADDR_W(10), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests;
  int          n_fail;
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd;
  int          lat_seen [int];

  function automatic int widx(input logic [31:0] addr);
    return int'(addr[11:2]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  // scoreboard checks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_lat(input string tag, input int lat);
    n_tests++;
    assert (lat >= LAT && lat <= LAT_MAX) else begin
      n_fail++;
      $error("FAIL %s: latency %0d expected %0d..%0d", tag, lat, LAT, LAT_MAX);
    end
  endtask

  // driver: call with the DUT idle, just after a rising edge
  task automatic do_op(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be,
                       output int lat, output logic [31:0] rdata);
    bus.mem_address     = addr;
    bus.mem_wdata       = data;
    bus.mem_byte_enable = be;
    bus.mem_write       = wr;
    bus.mem_read        = rd;
    @(posedge clk);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.mem_resp) break;
    end
    if (!bus.mem_resp) check("resp_timeout", {31'b0, bus.mem_resp}, 32'd1);
    rdata = bus.mem_rdata;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    check("resp_width", {31'b0, bus.mem_resp}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wr_op(input string tag, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be);
    int          lat;
    logic [31:0] rd;
    logic [31:0] old;
    do_op(1'b1, 1'b0, addr, data, be, lat, rd);
    check_lat({tag, "_lat"}, lat);
    check({tag, "_rdata_hold"}, rd, last_rd);
    old = ref_mem.exists(widx(addr)) ? ref_mem[widx(addr)] : 32'h0;
    ref_mem[widx(addr)] = merge(old, data, be);
  endtask

  task automatic rd_op(input string tag, input logic [31:0] addr);
    int          lat;
    logic [31:0] rd;
    do_op(1'b0, 1'b1, addr, $urandom, 4'($urandom), lat, rd);
    check_lat({tag, "_lat"}, lat);
    lat_seen[lat] = 1;
    check({tag, "_data"}, rd, ref_mem[widx(addr)]);
    last_rd = ref_mem[widx(addr)];
  endtask

  task automatic apply_reset();
    rst_n               = 1'b0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.mem_byte_enable = '0;
    #1;
    check("rst_resp", {31'b0, bus.mem_resp}, 32'd0);
    check("rst_rdata", bus.mem_rdata, 32'd0);
    check("rst_err", {31'b0, bus.mem_err}, 32'd0);
    last_rd = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    int          resp_cnt;
    logic [31:0] rd;
    logic [31:0] a;
    n_tests = 0;
    n_fail  = 0;
    last_rd = 32'h0;
    #3;
    apply_reset();

    // write then read
    wr_op("wr10", 32'h0000_0010, 32'hDEADBEEF, 4'b1111);
    rd_op("rd10", 32'h0000_0010);
    check("rd10_const", last_rd, 32'hDEADBEEF);

    // byte enables, including an all-zero enable write
    wr_op("pre20", 32'h0000_0020, 32'h11223344, 4'b1111);
    wr_op("be0001", 32'h0000_0020, 32'hAABBCCDD, 4'b0001);
    wr_op("be1100", 32'h0000_0020, 32'hAABBCCDD, 4'b1100);
    wr_op("be0000", 32'h0000_0020, 32'h55555555, 4'b0000);
    rd_op("rd20", 32'h0000_0020);
    check("rd20_const", last_rd, 32'hAABB33DD);

    // address wrap and ignored low bits
    wr_op("wrap_wr", 32'h0000_1004, 32'hCAFEF00D, 4'b1111);
    rd_op("wrap_rd", 32'h0000_0006);
    check("wrap_const", last_rd, 32'hCAFEF00D);
    check("err_clean", {31'b0, bus.mem_err}, 32'd0);

    // randomized traffic over a small window so addresses repeat
    for (int i = 0; i < 8; i++) wr_op("rnd_init", 32'h100 + 32'(i * 4), $urandom, 4'b1111);
    for (int i = 0; i < 40; i++) begin
      a = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3))
          + (32'($urandom_range(0, 3)) << 12);
      if ($urandom_range(0, 1) == 1) wr_op("rnd_wr", a, $urandom, 4'($urandom));
      else                           rd_op("rnd_rd", a);
    end

    // read and write together: serviced as a write, error flagged and sticky
    do_op(1'b1, 1'b1, 32'h0000_0030, 32'h12345678, 4'b1111, lat, rd);
    check_lat("rw_lat", lat);
    ref_mem[widx(32'h30)] = 32'h12345678;
    check("rw_err", {31'b0, bus.mem_err}, 32'd1);
    rd_op("rw_rd", 32'h0000_0030);
    check("err_sticky", {31'b0, bus.mem_err}, 32'd1);
    apply_reset();

    // read dropped in the first wait cycle: no response, error flagged
    bus.mem_address = 32'h0000_0010;
    bus.mem_read    = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_read = 1'b0;
    resp_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.mem_resp) resp_cnt++;
    end
    check("abort_noresp", 32'(resp_cnt), 32'd0);
    check("abort_err", {31'b0, bus.mem_err}, 32'd1);
    check("abort_rdata", bus.mem_rdata, 32'd0);
    @(posedge clk);
    #1;
    rd_op("after_abort", 32'h0000_0010);

    // reset during the wait of a write discards it
    wr_op("pre40", 32'h0000_0040, 32'h0000_0000, 4'b1111);
    bus.mem_address     = 32'h0000_0040;
    bus.mem_wdata       = 32'hFFFFFFFF;
    bus.mem_byte_enable = 4'b1111;
    bus.mem_write       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    apply_reset();
    rd_op("rst40", 32'h0000_0040);

`ifdef MEM_RESP_STALL_EN
    lat_seen.delete();
    for (int i = 0; i < 64; i++) rd_op("stall_rd", 32'h100 + 32'($urandom_range(0, 7) * 4));
    n_tests++;
    assert (lat_seen.num() >= 2) else begin
      n_fail++;
      $error("FAIL stall_spread: got %0d distinct latencies expected >=2", lat_seen.num());
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
